data_sram_resp: RTL
===================

# data_sram_resp

Data-side SRAM responder for the five-stage pipeline: the slave end of the `data_sram_*` interface driven by the MEM-stage access logic. It holds a word-organised, byte-writable data store. Writes are posted with zero wait. Reads return registered `data_sram_rdata` after a configurable number of wait states, and the block raises `stallreq` into the stall controller so the pipeline freezes while a read is outstanding.

## Interface

Parameters:
- `ADDR_W`, default 10: word-index width; depth = 2^ADDR_W 32-bit words.
- `WAIT`, default 0: read wait states, legal range 0..15.

Ports:
- `clk`  in  1: pipeline clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low (asserted at 0).
- `data_sram_en`  in  1: access request this cycle.
- `data_sram_wen`  in  4: byte write enables; bit i writes byte lane i (bits 8i+7:8i); all-zero with `en`=1 is a read.
- `data_sram_addr`  in  32: byte address.
- `data_sram_wdata`  in  32: write data.
- `data_sram_rdata`  out  32: registered read data; holds its value until the next read completes.
- `stallreq`  out  1: stall request to the stall controller; the pipeline holds the request inputs stable while it is 1.

## Operation

- Word index = `data_sram_addr[ADDR_W+1:2]`.
  - `addr[1:0]` is ignored.
  - Bits above `ADDR_W+1` are ignored (aliasing).
- Request decode:
  - `rd = en & (wen==0)`
  - `wr = en & (wen!=0)`
- Write, accepted only in IDLE:
  - Enabled byte lanes of `mem[idx]` are updated at the end of the request cycle.
  - Disabled lanes are unchanged.
  - `rdata` is untouched, no stall for any `WAIT`.
- Read with `WAIT`=0: `rdata <= mem[idx]` at the end of the request cycle; `stallreq` never asserts.
- Read with `WAIT`=N>0 uses a two-state FSM, IDLE and WAITING, with a 4-bit counter `cnt`:
  - IDLE & rd: `stallreq`=1 combinationally; next state WAITING, `cnt <= N-1`.
  - WAITING & `cnt`!=0 & en: `stallreq`=1; `cnt <= cnt-1`.
  - WAITING & `cnt`==0 & en (release cycle): `stallreq`=0; `rdata <= mem[idx]`; go to IDLE. The request present in this cycle is consumed and does not re-trigger.
  - WAITING & en==0 (flush/abort): `stallreq`=0; go to IDLE; `cnt` cleared; `rdata` unchanged.
- `stallreq = ~rst_asserted & ((IDLE & rd & WAIT!=0) | (WAITING & cnt!=0 & en))`.
- Requests in WAITING other than the held read are not expected. Writes seen in WAITING are ignored; there is no memory update.
- Single port: a read and a write never share a cycle. Read-after-write to the same word in the next request returns the new data.

## Timing

- Reset (rst=0, asynchronous):
  - State IDLE, `cnt`=0.
  - `data_sram_rdata`=32'h0.
  - `stallreq`=0 while `rst`=0.
  - Memory contents are not reset.
- Reset asserted mid-wait:
  - Immediate return to IDLE; `stallreq` drops in the same cycle.
  - The pending read is discarded and `rdata`=0.
- Write latency: data visible to a read issued in the next cycle.
- Read latency, request first presented in cycle T:
  - `WAIT`=0: `rdata` valid in T+1.
  - `WAIT`=N: `stallreq`=1 in cycles T..T+N-1, 0 in T+N; `rdata` valid from T+N+1.
- `rdata` is stable on every cycle where no read completes, including during writes and stalls.
- Back-to-back reads with `WAIT`=0: one per cycle, each returned the following cycle.

## Test plan

- Reset: drive rst=0 mid-stream with `WAIT`=3 during a pending read -> `rdata`=0 and `stallreq`=0 immediately. After release, state is IDLE and the next read starts a fresh 3-cycle stall.
- Byte-lane write (`WAIT`=0):
  - Write 32'hAABBCCDD with wen=4'hF to addr 0x10.
  - Then write 32'h11223344 with wen=4'b0101 to the same address.
  - Read addr 0x10 -> 32'hAA22CC44 the next cycle.
- Address aliasing (`ADDR_W`=10):
  - Write 32'h12345678 to 0x0000_0004.
  - Read 0x0000_1007 -> 32'h12345678 (addr[1:0] and bits above bit 11 ignored).
- Wait states (`WAIT`=2): read issued at T -> `stallreq` 1,1,0 in T, T+1, T+2. `rdata` updates only at T+3 and holds through a following write.
- Abort: `WAIT`=3, read at T, `en` dropped at T+1 -> `stallreq`=0 at T+1, `rdata` keeps its previous value, and a new read at T+2 stalls for a full 3 cycles.
- Streaming reads (`WAIT`=0): reads to words 0,1,2 on consecutive cycles -> `rdata` returns their contents on consecutive cycles with `stallreq` constantly 0.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-side SRAM responder for the MEM stage.
// Word-organised, byte-writable store. Writes are posted with no wait.
// Reads return registered data after WAIT wait states. stallreq freezes the
// pipeline while a read is outstanding.
module data_sram_resp #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,              // asynchronous, active-low
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  localparam int DEPTH = 1 << ADDR_W;
  // The first stall cycle is the request cycle, so the counter starts one short.
  localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    WAITING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q;
  logic              stall_d;
  logic              rd_done;
  logic              rd_req;
  logic              wr_req;
  logic              wr_go;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [DEPTH];

  // Byte offset and bits above the word index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign idx    = data_sram_addr[ADDR_W+1:2];
  assign rd_req = data_sram_en & (data_sram_wen == 4'h0);
  assign wr_req = data_sram_en & (data_sram_wen != 4'h0);
  // Writes arriving while a read is held are dropped.
  assign wr_go  = wr_req & (state_q == IDLE);

  // Next-state, wait counter and read-completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (WAIT == 0) begin
            rd_done = 1'b1;
          end else begin
            stall_d = 1'b1;
            state_d = WAITING;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAITING: begin
        if (!data_sram_en) begin
          // Pipeline flushed the held request: abandon it, keep old rdata.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          stall_d = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          // Release cycle: data lands this edge, the held request is consumed.
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Stall is combinational and forced low while reset is held.
  assign stallreq = rst & stall_d;

  // FSM state, wait counter and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_done) begin
        rdata_q <= mem[idx];
      end
    end
  end

  // Byte-lane writes to the store; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) begin
          mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;

endmodule
